instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's control decoder: accepts a stream of symbolic instruction descriptors (mnemonic plus register, immediate and target fields) and emits 32-bit MIPS machine words.
- Writes each word sequentially into instruction memory through a write port.
- Used by the test harness and the boot loader to program the single-cycle CPU without an external assembler.
- Covers exactly the 25 instructions the core decodes.

Parameters:
- AW, 10, instruction-memory word-address width; the memory holds DEPTH = 2**AW words.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr and begins a load session
- base_addr  in  AW  first word address of the session
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder accepts the descriptor this cycle
- in_last  in  1  the descriptor is the final one of the session
- in_mnem  in  5  mnemonic code, 0..24 legal (see package)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_imm  in  16  immediate
- in_target  in  26  jump target (word index)
- im_we  out  1  instruction-memory write strobe
- im_addr  out  AW  write word address
- im_wdata  out  32  encoded word
- busy  out  1  state is LOAD or DRAIN
- done  out  1  state is DONE
- err_illegal  out  1  sticky: an illegal mnemonic was seen
- err_overflow  out  1  sticky: the address wrapped past DEPTH-1
- count  out  AW+1  number of words written this session

Behaviour:
- Reset: state=IDLE; in_ready, im_we, busy, done, both err flags = 0; im_addr, im_wdata, count = 0. Reset mid-session aborts with no further writes.
- States: IDLE, LOAD, DRAIN, DONE.
  - IDLE/DONE + start -> LOAD: latch base_addr into the address counter; clear count and both err flags. Start in LOAD/DRAIN is ignored.
  - LOAD: in_ready = 1. A transfer occurs on in_valid & in_ready. A transfer with in_last -> DRAIN.
  - DRAIN: in_ready = 0. One cycle, letting the final word retire, then -> DONE.
  - DONE: holds until the next start.
- Pipeline: one register stage. A transfer in cycle N produces im_we=1 in cycle N+1, with im_addr equal to the current counter and im_wdata equal to the encoded word. The counter and count increment on each write. Throughput is 1 word/cycle; the memory never back-pressures.
- Illegal mnemonic (25..31): set err_illegal; no write; counter unchanged. The descriptor is still consumed, and in_last still ends the session.
- Address wrap: a write at address DEPTH-1 sets err_overflow. The counter wraps to 0 and writing continues.
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]; imm in [15:0]; target in [25:0].
- R-type (op=0), funct values:
  - add 0x20, addu 0x21, sub 0x22, subu 0x23
  - and 0x24, or 0x25, nor 0x27
  - slt 0x2A, sltu 0x2B
  - sll 0x00, srl 0x02, sllv 0x04
  - jr 0x08, jalr 0x09
- R-type field forcing:
  - shamt is forced to 0 except for sll and srl.
  - rs is forced to 0 for sll and srl.
  - jr forces rt, rd and shamt to 0.
- I-type opcodes: addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F, beq 0x04, bne 0x05, lw 0x23, sw 0x2B. lui forces rs=0.
- J-type opcodes: j 0x02, jal 0x03.
- Fields are inserted verbatim. The encoder does no sign or range checking; immediates are the caller's responsibility.
- Simultaneous events:
  - A last transfer while the final write occurs: both happen.
  - A wrap on the last word: err_overflow is set and the session still completes.

Decomposition:
- Package instr_enc_pkg:
  - mnemonic enum (add=0, sub, and, or, slt, sltu, addu, subu, sll, nor, srl, sllv, jr, jalr, addi, ori, lw, sw, beq, lui, slti, andi, j, jal, bne=24)
  - opcode and funct localparams
  - state enum
- Sub-module instr_enc_word: purely combinational mnemonic+fields -> {word, legal}. It is reused by the bench's scoreboard.

Test Plan:
- start with base_addr=0x010, then a single addi rt=8, rs=0, imm=5 with last=1 -> one cycle later im_we=1, im_addr=0x010, im_wdata=0x20080005; done two cycles after the transfer; count=1.
- Back-to-back add rd=10, rs=8, rt=9 then sw rt=8, rs=29, imm=4 (last) -> consecutive writes 0x01095020 @0x000 and 0xAFA80004 @0x001; in_ready stays 1 until last.
- j target=0x0100000, then a descriptor with mnem=27, then sll rd=2, rt=3, shamt=4, rs=7 (last) -> 0x08100000 @0, no write for 27, 0x00031100 @1; err_illegal=1; count=2.
- base_addr=DEPTH-1, two beq descriptors -> writes at 0x3FF then 0x000; err_overflow=1.
- rstn asserted low between two transfers -> all outputs 0 immediately; no further im_we after release; state IDLE.
- start pulsed during LOAD -> ignored; base and count are unchanged.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder: mnemonic codes, MIPS opcode/funct
// values, loader state encoding and small field-packing helpers.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,
        MN_SUB  = 5'd1,
        MN_AND  = 5'd2,
        MN_OR   = 5'd3,
        MN_SLT  = 5'd4,
        MN_SLTU = 5'd5,
        MN_ADDU = 5'd6,
        MN_SUBU = 5'd7,
        MN_SLL  = 5'd8,
        MN_NOR  = 5'd9,
        MN_SRL  = 5'd10,
        MN_SLLV = 5'd11,
        MN_JR   = 5'd12,
        MN_JALR = 5'd13,
        MN_ADDI = 5'd14,
        MN_ORI  = 5'd15,
        MN_LW   = 5'd16,
        MN_SW   = 5'd17,
        MN_BEQ  = 5'd18,
        MN_LUI  = 5'd19,
        MN_SLTI = 5'd20,
        MN_ANDI = 5'd21,
        MN_J    = 5'd22,
        MN_JAL  = 5'd23,
        MN_BNE  = 5'd24
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_enc_word.sv
// Combinational mnemonic-plus-fields to 32-bit MIPS word encoder. Fields are
// inserted verbatim apart from the per-instruction zero forcing.
module instr_enc_word
    import instr_enc_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (mnem_i)
            MN_ADD:  word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            MN_ADDU: word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_ADDU);
            MN_SUB:  word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            MN_SUBU: word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_SUBU);
            MN_AND:  word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            MN_OR:   word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            MN_NOR:  word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
            MN_SLT:  word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
            MN_SLTU: word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_SLTU);
            MN_SLLV: word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_SLLV);
            // Immediate shifts carry the amount in shamt and leave rs unused.
            MN_SLL:  word_o = r_type(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
            MN_SRL:  word_o = r_type(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
            MN_JR:   word_o = r_type(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_JALR: word_o = r_type(rs_i, rt_i, rd_i, 5'd0, FN_JALR);
            MN_ADDI: word_o = i_type(OP_ADDI, rs_i, rt_i, imm_i);
            MN_SLTI: word_o = i_type(OP_SLTI, rs_i, rt_i, imm_i);
            MN_ANDI: word_o = i_type(OP_ANDI, rs_i, rt_i, imm_i);
            MN_ORI:  word_o = i_type(OP_ORI,  rs_i, rt_i, imm_i);
            MN_LUI:  word_o = i_type(OP_LUI,  5'd0, rt_i, imm_i);
            MN_BEQ:  word_o = i_type(OP_BEQ,  rs_i, rt_i, imm_i);
            MN_BNE:  word_o = i_type(OP_BNE,  rs_i, rt_i, imm_i);
            MN_LW:   word_o = i_type(OP_LW,   rs_i, rt_i, imm_i);
            MN_SW:   word_o = i_type(OP_SW,   rs_i, rt_i, imm_i);
            MN_J:    word_o = j_type(OP_J,   target_i);
            MN_JAL:  word_o = j_type(OP_JAL, target_i);
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams symbolic instruction descriptors into instruction memory as encoded
// MIPS words, one register stage between acceptance and the memory write.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [4:0]    in_mnem,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic          err_illegal,
    output logic          err_overflow,
    output logic [AW:0]   count
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   count_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic          err_ill_q;
    logic          err_ovf_q;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          xfer;
    logic          start_ok;

    instr_enc_word u_word (
        .mnem_i   (in_mnem),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .rd_i     (in_rd),
        .shamt_i  (in_shamt),
        .imm_i    (in_imm),
        .target_i (in_target),
        .word_o   (enc_word),
        .legal_o  (enc_legal)
    );

    assign in_ready = (state_q == ST_LOAD);
    assign xfer     = in_valid & in_ready;
    // A start while a session is in flight is ignored so the base cannot move.
    assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_LOAD;
            ST_LOAD:  if (xfer && in_last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (start_ok) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= xfer & enc_legal;
            if (xfer) wdata_q <= enc_word;

            if (start_ok) begin
                addr_q    <= base_addr;
                count_q   <= '0;
                err_ill_q <= 1'b0;
                err_ovf_q <= 1'b0;
            end else begin
                if (we_q) begin
                    addr_q  <= addr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                    if (addr_q == {AW{1'b1}}) err_ovf_q <= 1'b1;
                end
                if (xfer && !enc_legal) err_ill_q <= 1'b1;
            end
        end
    end

    assign im_we        = we_q;
    assign im_addr      = addr_q;
    assign im_wdata     = wdata_q;
    assign busy         = (state_q == ST_LOAD) | (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign err_illegal  = err_ill_q;
    assign err_overflow = err_ovf_q;
    assign count        = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: an independent reference encoder pushes
// expected writes when descriptors are driven; a monitor pops them on writes.
module tb_instr_encoder;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [4:0]    in_mnem = '0;
    logic [4:0]    in_rs = '0;
    logic [4:0]    in_rt = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_shamt = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy;
    logic          done;
    logic          err_illegal;
    logic          err_overflow;
    logic [AW:0]   count;

    instr_encoder #(.AW(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_mnem      (in_mnem),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_shamt     (in_shamt),
        .in_imm       (in_imm),
        .in_target    (in_target),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .busy         (busy),
        .done         (done),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] exp_addr = '0;
    int            exp_count = 0;
    bit            exp_ill = 1'b0;
    bit            exp_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder written from the instruction tables, shift-and-or style.
    function automatic logic [31:0] ref_word(input int m, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt, output bit legal);
        int op, fn, kind;
        legal = 1'b1;
        op = 0; fn = 0; kind = 0;
        case (m)
            0:  fn = 'h20;  1: fn = 'h22;  2: fn = 'h24;  3: fn = 'h25;
            4:  fn = 'h2A;  5: fn = 'h2B;  6: fn = 'h21;  7: fn = 'h23;
            8:  fn = 'h00;  9: fn = 'h27; 10: fn = 'h02; 11: fn = 'h04;
            12: fn = 'h08; 13: fn = 'h09;
            14: begin kind = 1; op = 'h08; end
            15: begin kind = 1; op = 'h0D; end
            16: begin kind = 1; op = 'h23; end
            17: begin kind = 1; op = 'h2B; end
            18: begin kind = 1; op = 'h04; end
            19: begin kind = 1; op = 'h0F; rs = 0; end
            20: begin kind = 1; op = 'h0A; end
            21: begin kind = 1; op = 'h0C; end
            22: begin kind = 2; op = 'h02; end
            23: begin kind = 2; op = 'h03; end
            24: begin kind = 1; op = 'h05; end
            default: legal = 1'b0;
        endcase
        if (kind == 0) begin
            if (m == 8 || m == 10) rs = 0;
            else sh = 0;
            if (m == 12) begin rt = 0; rd = 0; end
        end
        case (kind)
            0: return (32'(rs & 31) << 21) | (32'(rt & 31) << 16) | (32'(rd & 31) << 11)
                      | (32'(sh & 31) << 6) | 32'(fn);
            1: return (32'(op) << 26) | (32'(rs & 31) << 21) | (32'(rt & 31) << 16)
                      | 32'(imm & 'hFFFF);
            default: return (32'(op) << 26) | 32'(tgt & 'h3FFFFFF);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rstn && im_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(im_addr), 64'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 64'(im_addr), 64'(e.addr));
                check("wr_data", 64'(im_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic start_session(input logic [AW-1:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = b; exp_count = 0; exp_ill = 1'b0; exp_ovf = 1'b0;
        check("start_ready", 64'(in_ready), 64'd1);
        check("start_count", 64'(count), 64'd0);
    endtask

    task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        int  n;
        bit  legal;
        logic [31:0] w;
        in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 64'd0, 64'd1);
        w = ref_word(int'(m), int'(rs), int'(rt), int'(rd), int'(sh), int'(imm), int'(tgt), legal);
        if (legal) begin
            sb_q.push_back('{addr: exp_addr, data: w});
            if (exp_addr == AW'(DEPTH - 1)) exp_ovf = 1'b1;
            exp_addr = exp_addr + 1'b1;
            exp_count++;
        end else begin
            exp_ill = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    64'(im_we), 64'd0);
        check({tag, "_addr"},  64'(im_addr), 64'd0);
        check({tag, "_wdata"}, 64'(im_wdata), 64'd0);
        check({tag, "_flags"}, 64'({in_ready, busy, done, err_illegal, err_overflow}), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Single addi, latency and done timing
        start_session(AW'('h010));
        send(5'd14, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b1);
        check("t1_we", 64'(im_we), 64'd1);
        check("t1_addr", 64'(im_addr), 64'h010);
        check("t1_data", 64'(im_wdata), 64'h20080005);
        check("t1_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_count", 64'(count), 64'd1);

        // Back-to-back add / sw
        start_session('0);
        send(5'd0, 5'd8, 5'd9, 5'd10, 5'd0, 16'd0, 26'd0, 1'b0);
        check("t2_ready", 64'(in_ready), 64'd1);
        check("t2_data0", 64'(im_wdata), 64'h01095020);
        send(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, 1'b1);
        check("t2_data1", 64'(im_wdata), 64'hAFA80004);
        check("t2_addr1", 64'(im_addr), 64'h001);
        wait_done();
        check("t2_count", 64'(count), 64'd2);

        // j, illegal mnemonic, sll with forced rs
        start_session('0);
        send(5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100000, 1'b0);
        send(5'd27, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'd0, 1'b0);
        check("t3_no_we", 64'(im_we), 64'd0);
        send(5'd8, 5'd7, 5'd3, 5'd2, 5'd4, 16'd0, 26'd0, 1'b1);
        check("t3_sll", 64'(im_wdata), 64'h00031100);
        check("t3_sll_addr", 64'(im_addr), 64'h001);
        wait_done();
        check("t3_ill", 64'(err_illegal), 64'd1);
        check("t3_ovf", 64'(err_overflow), 64'd0);
        check("t3_count", 64'(count), 64'd2);

        // Address wrap on the last word
        start_session(AW'(DEPTH - 1));
        send(5'd18, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFC, 26'd0, 1'b0);
        send(5'd18, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0008, 26'd0, 1'b1);
        check("t4_wrap_addr", 64'(im_addr), 64'h000);
        check("t4_ovf_early", 64'(err_overflow), 64'd1);
        wait_done();
        check("t4_ovf", 64'(err_overflow), 64'd1);
        check("t4_count", 64'(count), 64'd2);

        // Start during LOAD is ignored
        start_session(AW'('h020));
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        start = 1'b1; base_addr = AW'('h100);
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_busy", 64'(busy), 64'd1);
        send(5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0, 1'b1);
        check("t5_addr", 64'(im_addr), 64'h021);
        wait_done();
        check("t5_count", 64'(count), 64'd2);

        // Reset between transfers aborts pending writes
        start_session(AW'('h040));
        send(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b0);
        send(5'd16, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'd0, 1'b0);
        rstn = 1'b0;
        sb_q.delete();
        #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        rstn = 1'b1;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_idle_ready", 64'(in_ready), 64'd0);
        check("rst_idle_state", 64'({busy, done}), 64'd0);
        check("rst_count", 64'(count), 64'd0);

        // Random sessions with gaps and occasional illegal codes
        for (int s = 0; s < 4; s++) begin
            start_session(AW'($urandom_range(0, DEPTH - 1)));
            for (int i = 0; i < 16; i++) begin
                logic [4:0] m;
                m = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31))
                                                : 5'($urandom_range(0, 24));
                send(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     16'($urandom), 26'($urandom), (i == 15) ? 1'b1 : 1'b0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                if (i != 15) #0;
            end
            wait_done();
            check("rnd_count", 64'(count), 64'(exp_count));
            check("rnd_ill", 64'(err_illegal), 64'(exp_ill));
            check("rnd_ovf", 64'(err_overflow), 64'(exp_ovf));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
